// File: rtl/snn_inference_ctrl_pkg.sv
// Shared types and constants for the SNN inference controller.
// State encoding, class codes and tally indices.
package snn_inference_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam logic [1:0] CLASS_0    = 2'b00;
    localparam logic [1:0] CLASS_1    = 2'b01;
    localparam logic [1:0] CLASS_2    = 2'b10;
    localparam logic [1:0] CLASS_NONE = 2'b11;

    localparam logic [1:0] OUT_C0 = 2'd0;
    localparam logic [1:0] OUT_C1 = 2'd1;
    localparam logic [1:0] OUT_C2 = 2'd2;
    localparam logic [1:0] OUT_TO = 2'd3;

endpackage

// File: rtl/snn_inference_ctrl_if.sv
// Host-side start / result handshake bundle.
// master = host, slave = inference controller.
interface snn_inference_ctrl_if #(
    parameter int CNT_W = 9
);
    logic             start_valid;
    logic             start_ready;
    logic             result_valid;
    logic             result_ready;
    logic [1:0]       result_class;
    logic             result_timeout;
    logic [CNT_W-1:0] result_ticks;

    modport master (
        output start_valid,
        output result_ready,
        input  start_ready,
        input  result_valid,
        input  result_class,
        input  result_timeout,
        input  result_ticks
    );

    modport slave (
        input  start_valid,
        input  result_ready,
        output start_ready,
        output result_valid,
        output result_class,
        output result_timeout,
        output result_ticks
    );
endinterface

// File: rtl/snn_sat_counter.sv
// Saturating up-counter used for the outcome tallies.
// Holds at all-ones instead of wrapping.
module snn_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc, stick at the maximum value.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/snn_inference_ctrl.sv
// Inference window controller: clears the arbitrator, runs the timer,
// captures the class result and keeps per-outcome tallies.
module snn_inference_ctrl
    import snn_inference_ctrl_pkg::*;
#(
    parameter int DURATION  = 300,
    parameter int CNT_W     = 9,
    parameter int CLEAR_CYC = 2,
    parameter int TICK_DIV  = 1,
    parameter int STAT_W    = 16
) (
    input  logic              clk,
    input  logic              resetn,
    snn_inference_ctrl_if.slave host,
    input  logic              end_process,
    input  logic              no_spike,
    input  logic [1:0]        class_in,
    output logic              arb_clear,
    output logic              timer_en,
    output logic              net_run,
    input  logic [1:0]        stat_sel,
    output logic [STAT_W-1:0] stat_count
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CLR_W = $clog2(CLEAR_CYC + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYC - 1);
    // Arbitrator gets two spare ticks before it is considered stuck.
    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(DURATION + 2);

    state_t           state;
    logic [CLR_W-1:0] clr_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic [CNT_W-1:0] tick_cnt;
    logic             run_first;

    logic             start_ready_q;
    logic             result_valid_q;
    logic [1:0]       result_class_q;
    logic             result_timeout_q;
    logic [CNT_W-1:0] result_ticks_q;

    logic             cap_spike;
    logic             cap_timeout;
    logic [3:0]       tally_inc;
    logic [STAT_W-1:0] tally [4];

    assign host.start_ready    = start_ready_q;
    assign host.result_valid   = result_valid_q;
    assign host.result_class   = result_class_q;
    assign host.result_timeout = result_timeout_q;
    assign host.result_ticks   = result_ticks_q;

    assign div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);

    // Capture decision; the first RUN cycle is skipped because the
    // arbitrator counter was only just reloaded.
    always_comb begin
        cap_spike   = 1'b0;
        cap_timeout = 1'b0;
        if ((state == ST_RUN) && !run_first) begin
            if (end_process && (class_in != CLASS_NONE)) begin
                cap_spike = 1'b1;
            end else if (end_process && (no_spike || (class_in == CLASS_NONE))) begin
                cap_timeout = 1'b1;
            end else if (tick_cnt >= WD_LIMIT) begin
                cap_timeout = 1'b1;
            end
        end
    end

    // One increment pulse per captured outcome.
    always_comb begin
        tally_inc         = '0;
        tally_inc[OUT_C0] = cap_spike && (class_in == CLASS_0);
        tally_inc[OUT_C1] = cap_spike && (class_in == CLASS_1);
        tally_inc[OUT_C2] = cap_spike && (class_in == CLASS_2);
        tally_inc[OUT_TO] = cap_timeout;
    end

    for (genvar g = 0; g < 4; g++) begin : g_tally
        snn_sat_counter #(
            .W(STAT_W)
        ) u_cnt (
            .clk   (clk),
            .resetn(resetn),
            .clear (1'b0),
            .inc   (tally_inc[g]),
            .count (tally[g])
        );
    end

    assign stat_count = tally[stat_sel];

    // Window sequencing with registered control and result outputs.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state            <= ST_IDLE;
            clr_cnt          <= '0;
            div_cnt          <= '0;
            tick_cnt         <= '0;
            run_first        <= 1'b0;
            arb_clear        <= 1'b1;
            timer_en         <= 1'b0;
            net_run          <= 1'b0;
            start_ready_q    <= 1'b0;
            result_valid_q   <= 1'b0;
            result_class_q   <= CLASS_NONE;
            result_timeout_q <= 1'b0;
            result_ticks_q   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    arb_clear     <= 1'b1;
                    start_ready_q <= 1'b1;
                    if (host.start_valid && start_ready_q) begin
                        state         <= ST_CLEAR;
                        start_ready_q <= 1'b0;
                        clr_cnt       <= '0;
                        div_cnt       <= '0;
                        tick_cnt      <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt == CLR_LAST) begin
                        state     <= ST_RUN;
                        arb_clear <= 1'b0;
                        net_run   <= 1'b1;
                        run_first <= 1'b1;
                        div_cnt   <= '0;
                        timer_en  <= (TICK_DIV == 1);
                    end else begin
                        clr_cnt <= clr_cnt + CLR_W'(1);
                    end
                end
                ST_RUN: begin
                    run_first <= 1'b0;
                    if (timer_en) begin
                        tick_cnt <= tick_cnt + CNT_W'(1);
                    end
                    if (cap_spike || cap_timeout) begin
                        state            <= ST_DONE;
                        timer_en         <= 1'b0;
                        net_run          <= 1'b0;
                        result_valid_q   <= 1'b1;
                        result_class_q   <= cap_spike ? class_in : CLASS_NONE;
                        result_timeout_q <= cap_timeout;
                        result_ticks_q   <= tick_cnt;
                    end else begin
                        div_cnt  <= div_nxt;
                        timer_en <= (div_nxt == DIV_LAST);
                    end
                end
                ST_DONE: begin
                    if (host.result_ready) begin
                        state          <= ST_IDLE;
                        result_valid_q <= 1'b0;
                        arb_clear      <= 1'b1;
                        start_ready_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snn_inference_ctrl.sv
// Directed bench for snn_inference_ctrl: default instance plus a
// TICK_DIV=3 / STAT_W=2 instance for divider, watchdog and saturation.
module tb_snn_inference_ctrl;

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    snn_inference_ctrl_if #(.CNT_W(9)) ha ();
    snn_inference_ctrl_if #(.CNT_W(9)) hb ();

    logic        ep_a, ns_a, ep_b, ns_b;
    logic [1:0]  cls_a, cls_b;
    logic        clr_a, te_a, nr_a, clr_b, te_b, nr_b;
    logic [1:0]  sel_a, sel_b;
    logic [15:0] stat_a;
    logic [1:0]  stat_b;

    snn_inference_ctrl u_a (
        .clk        (clk),
        .resetn     (resetn),
        .host       (ha.slave),
        .end_process(ep_a),
        .no_spike   (ns_a),
        .class_in   (cls_a),
        .arb_clear  (clr_a),
        .timer_en   (te_a),
        .net_run    (nr_a),
        .stat_sel   (sel_a),
        .stat_count (stat_a)
    );

    snn_inference_ctrl #(
        .TICK_DIV(3),
        .STAT_W  (2)
    ) u_b (
        .clk        (clk),
        .resetn     (resetn),
        .host       (hb.slave),
        .end_process(ep_b),
        .no_spike   (ns_b),
        .class_in   (cls_b),
        .arb_clear  (clr_b),
        .timer_en   (te_b),
        .net_run    (nr_b),
        .stat_sel   (sel_b),
        .stat_count (stat_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_clr"}, 32'(clr_a), 32'd1);
        chk({tag, "_te"}, 32'(te_a), 32'd0);
        chk({tag, "_nr"}, 32'(nr_a), 32'd0);
        chk({tag, "_srdy"}, 32'(ha.start_ready), 32'd0);
        chk({tag, "_rval"}, 32'(ha.result_valid), 32'd0);
        chk({tag, "_rcls"}, 32'(ha.result_class), 32'd3);
        chk({tag, "_rto"}, 32'(ha.result_timeout), 32'd0);
        chk({tag, "_rtk"}, 32'(ha.result_ticks), 32'd0);
        for (int k = 0; k < 4; k++) begin
            sel_a = 2'(k);
            #1;
            chk({tag, "_tally"}, 32'(stat_a), 32'd0);
        end
    endtask

    task automatic wait_ready_a();
        int g;
        g = 0;
        while (!ha.start_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) chk("a_start_ready_wait", 32'd0, 32'd1);
    endtask

    task automatic wait_valid_a();
        int g;
        g = 0;
        while (!ha.result_valid && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 2000) chk("a_result_wait", 32'd0, 32'd1);
    endtask

    task automatic start_b();
        int g;
        g = 0;
        while (!hb.start_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) chk("b_start_ready_wait", 32'd0, 32'd1);
        hb.start_valid = 1'b1;
        @(negedge clk);
        hb.start_valid = 1'b0;
    endtask

    task automatic wait_valid_b();
        int g;
        g = 0;
        while (!hb.result_valid && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 2000) chk("b_result_wait", 32'd0, 32'd1);
    endtask

    task automatic release_a();
        ha.result_ready = 1'b1;
        @(negedge clk);
        ha.result_ready = 1'b0;
        chk("a_release_valid", 32'(ha.result_valid), 32'd0);
    endtask

    task automatic release_b();
        hb.result_ready = 1'b1;
        @(negedge clk);
        hb.result_ready = 1'b0;
    endtask

    // Start a window on A; the arbitrator model counts timer ticks and
    // reports end_process in the cycle it has seen n of them.
    task automatic run_a(input int n, input logic ns, input logic [1:0] cls);
        int cnt;
        int g;
        cnt = 0;
        g   = 0;
        wait_ready_a();
        ha.start_valid = 1'b1;
        @(negedge clk);
        ha.start_valid = 1'b0;
        while (cnt != n && g < 2000) begin
            if (te_a) cnt++;
            @(negedge clk);
            g++;
        end
        if (g >= 2000) chk("a_tick_wait", 32'd0, 32'd1);
        chk("a_te_at_capture", 32'(te_a), 32'd1);
        chk("a_nr_at_capture", 32'(nr_a), 32'd1);
        ep_a  = 1'b1;
        ns_a  = ns;
        cls_a = cls;
        @(negedge clk);
        ep_a  = 1'b0;
        ns_a  = 1'b0;
        cls_a = 2'b11;
    endtask

    logic [5:0] te_pat;

    initial begin
        resetn          = 1'b1;
        ha.start_valid  = 1'b0;
        ha.result_ready = 1'b0;
        hb.start_valid  = 1'b0;
        hb.result_ready = 1'b0;
        ep_a  = 1'b0;
        ns_a  = 1'b0;
        cls_a = 2'b11;
        ep_b  = 1'b0;
        ns_b  = 1'b0;
        cls_b = 2'b11;
        sel_a = 2'd0;
        sel_b = 2'd0;
        te_pat = 6'b100100;
        #1;
        chk_reset_a("rst0");
        chk("rst0_b_clr", 32'(clr_b), 32'd1);
        chk("rst0_b_srdy", 32'(hb.start_ready), 32'd0);

        repeat (2) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk("idle_srdy", 32'(ha.start_ready), 32'd1);
        chk("idle_clr", 32'(clr_a), 32'd1);

        // Spike at tick 37, class 01.
        run_a(37, 1'b0, 2'b01);
        chk("spk_valid", 32'(ha.result_valid), 32'd1);
        chk("spk_class", 32'(ha.result_class), 32'd1);
        chk("spk_to", 32'(ha.result_timeout), 32'd0);
        chk("spk_ticks", 32'(ha.result_ticks), 32'd37);
        chk("spk_te_off", 32'(te_a), 32'd0);
        chk("spk_nr_off", 32'(nr_a), 32'd0);
        chk("spk_srdy", 32'(ha.start_ready), 32'd0);
        sel_a = 2'd1;
        #1;
        chk("spk_tally1", 32'(stat_a), 32'd1);
        release_a();

        // Arbitrator-reported timeout at tick 300.
        run_a(300, 1'b1, 2'b11);
        chk("to_valid", 32'(ha.result_valid), 32'd1);
        chk("to_class", 32'(ha.result_class), 32'd3);
        chk("to_to", 32'(ha.result_timeout), 32'd1);
        chk("to_ticks", 32'(ha.result_ticks), 32'd300);
        sel_a = 2'd3;
        #1;
        chk("to_tally3", 32'(stat_a), 32'd1);
        sel_a = 2'd1;
        #1;
        chk("to_tally1", 32'(stat_a), 32'd1);
        release_a();

        // end_process held from idle: ignored until the second RUN cycle.
        ep_a  = 1'b1;
        cls_a = 2'b00;
        wait_ready_a();
        ha.start_valid = 1'b1;
        @(negedge clk);
        ha.start_valid = 1'b0;
        wait_valid_a();
        ep_a  = 1'b0;
        cls_a = 2'b11;
        chk("early_class", 32'(ha.result_class), 32'd0);
        chk("early_to", 32'(ha.result_timeout), 32'd0);
        chk("early_ticks", 32'(ha.result_ticks), 32'd1);
        sel_a = 2'd0;
        #1;
        chk("early_tally0", 32'(stat_a), 32'd1);
        release_a();

        // Spike and no_spike together: spike wins.
        run_a(5, 1'b1, 2'b10);
        chk("sim_class", 32'(ha.result_class), 32'd2);
        chk("sim_to", 32'(ha.result_timeout), 32'd0);
        chk("sim_ticks", 32'(ha.result_ticks), 32'd5);
        sel_a = 2'd2;
        #1;
        chk("sim_tally2", 32'(stat_a), 32'd1);

        // Backpressure with a pending start request.
        ha.start_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("bp_valid", 32'(ha.result_valid), 32'd1);
            chk("bp_class", 32'(ha.result_class), 32'd2);
            chk("bp_ticks", 32'(ha.result_ticks), 32'd5);
            chk("bp_srdy", 32'(ha.start_ready), 32'd0);
        end
        ha.result_ready = 1'b1;
        @(negedge clk);
        ha.result_ready = 1'b0;
        chk("bp_rel_valid", 32'(ha.result_valid), 32'd0);
        chk("bp_rel_srdy", 32'(ha.start_ready), 32'd1);
        @(negedge clk);
        ha.start_valid = 1'b0;
        chk("bp_acc_srdy", 32'(ha.start_ready), 32'd0);
        chk("clr_c0", 32'(clr_a), 32'd1);
        @(negedge clk);
        chk("clr_c1", 32'(clr_a), 32'd1);
        chk("clr_c1_nr", 32'(nr_a), 32'd0);
        @(negedge clk);
        chk("run0_clr", 32'(clr_a), 32'd0);
        chk("run0_nr", 32'(nr_a), 32'd1);
        chk("run0_te", 32'(te_a), 32'd1);
        @(negedge clk);

        // Asynchronous reset in the middle of a window.
        #2;
        resetn = 1'b1;
        #1;
        chk_reset_a("rst_mid");
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk("rst_mid_srdy", 32'(ha.start_ready), 32'd1);

        // TICK_DIV=3 with a silent arbitrator: watchdog capture.
        start_b();
        begin
            int g;
            g = 0;
            while (!nr_b && g < 20) begin
                @(negedge clk);
                g++;
            end
            if (g >= 20) chk("b_run_wait", 32'd0, 32'd1);
        end
        for (int k = 0; k < 6; k++) begin
            chk("div3_te", 32'(te_b), 32'(te_pat[k]));
            @(negedge clk);
        end
        wait_valid_b();
        chk("wd_class", 32'(hb.result_class), 32'd3);
        chk("wd_to", 32'(hb.result_timeout), 32'd1);
        chk("wd_ticks", 32'(hb.result_ticks), 32'd302);
        sel_b = 2'd3;
        #1;
        chk("wd_tally3", 32'(stat_b), 32'd1);
        release_b();
        for (int r = 0; r < 4; r++) begin
            start_b();
            wait_valid_b();
            release_b();
        end
        sel_b = 2'd3;
        #1;
        chk("sat_tally3", 32'(stat_b), 32'd3);
        sel_b = 2'd0;
        #1;
        chk("sat_tally0", 32'(stat_b), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
